// File: rtl/br_level_chain.sv
//==============================================================================
// Module      : br_level_chain
// Description : One Unibus BR level: arbitrates NDEV device requests and runs
//               the BR/BG/SACK/BBSY/INTR handshake, returning a grant pulse.
//               Optional SACK-to-SSYN timeout: `define BR_LEVEL_CHAIN_TIMEOUT_EN
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module br_level_chain #(
    parameter int NDEV           = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    input  logic [NDEV-1:0]     dev_intreq,
    input  logic [8*NDEV-1:0]   dev_irvec,
    output logic [NDEV-1:0]     dev_intgnt,
    output logic [7:0]          dev_igvec,
    input  logic                init_in_h,
    input  logic                bg_in_h,
    output logic                bg_out_h,
    input  logic                bbsy_in_h,
    input  logic                ssyn_in_h,
    output logic                br_out_h,
    output logic                sack_out_h,
    output logic                bbsy_out_h,
    output logic                intr_out_h,
    output logic [15:0]         d_out_h
`ifdef BR_LEVEL_CHAIN_TIMEOUT_EN
    ,
    output logic                stat_timeout
`endif
);

    localparam int c_IDXW = (NDEV > 1) ? $clog2(NDEV) : 1;

    if (NDEV < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("br_level_chain: NDEV and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLAIM  = 2'd1,
        S_MASTER = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [c_IDXW-1:0]   r_winner;
    logic [c_IDXW-1:0]   w_winner_n;
    logic [7:0]          r_vec;
    logic [7:0]          w_vec_n;
    logic                r_passed;
    logic                w_passed_n;

    logic                w_bg_n;
    logic                w_br_n;
    logic                w_sack_n;
    logic                w_bbsy_n;
    logic                w_intr_n;
    logic [15:0]         w_d_n;
    logic [NDEV-1:0]     w_gnt_n;
    logic [7:0]          w_igvec_n;
    logic                w_br_kill;

    logic                w_any;
    logic [c_IDXW-1:0]   w_win_idx;
    logic [7:0]          w_win_vec;

`ifdef BR_LEVEL_CHAIN_TIMEOUT_EN
    localparam int               c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic [c_TMO_W-1:0]  w_tmo_cnt_n;
    logic                w_stat_n;
`endif

    // Fixed priority: lowest index wins, scanned downward so index 0 overrides.
    always_comb begin
        w_any     = |dev_intreq;
        w_win_idx = '0;
        w_win_vec = dev_irvec[7:0];
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (dev_intreq[i]) begin
                w_win_idx = c_IDXW'(i);
                w_win_vec = dev_irvec[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_winner_n = r_winner;
        w_vec_n    = r_vec;
        w_passed_n = r_passed;
        w_bg_n     = 1'b0;
        w_sack_n   = sack_out_h;
        w_bbsy_n   = bbsy_out_h;
        w_intr_n   = intr_out_h;
        w_d_n      = d_out_h;
        w_gnt_n    = '0;
        w_igvec_n  = 8'h00;
        w_br_kill  = 1'b0;
`ifdef BR_LEVEL_CHAIN_TIMEOUT_EN
        w_tmo_cnt_n = r_tmo_cnt;
        w_stat_n    = stat_timeout;
`endif

        case (r_state)
            S_IDLE: begin
                if (bg_in_h) begin
                    // Once the grant has been passed on, it belongs downstream
                    // until BG drops, even if a local request shows up.
                    if (r_passed) begin
                        w_bg_n = 1'b1;
                    end else if (w_any) begin
                        w_winner_n = w_win_idx;
                        w_vec_n    = w_win_vec;
                        w_sack_n   = 1'b1;
                        w_state_n  = S_CLAIM;
`ifdef BR_LEVEL_CHAIN_TIMEOUT_EN
                        w_tmo_cnt_n = '0;
`endif
                    end else begin
                        w_bg_n     = 1'b1;
                        w_passed_n = 1'b1;
                    end
                end else begin
                    w_passed_n = 1'b0;
                end
            end

            S_CLAIM: begin
                if (!bg_in_h && !bbsy_in_h && !ssyn_in_h) begin
                    w_sack_n = 1'b0;
                    if (dev_intreq[r_winner]) begin
                        w_bbsy_n  = 1'b1;
                        w_intr_n  = 1'b1;
                        w_d_n     = {8'h00, r_vec};
                        w_state_n = S_MASTER;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end

            S_MASTER: begin
                if (ssyn_in_h) begin
                    w_intr_n           = 1'b0;
                    w_bbsy_n           = 1'b0;
                    w_d_n              = 16'h0000;
                    w_gnt_n[r_winner]  = 1'b1;
                    w_igvec_n          = r_vec;
                    w_state_n          = S_DONE;
                end
            end

            S_DONE: begin
                if (!ssyn_in_h) begin
                    w_state_n = S_IDLE;
                end
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase

`ifdef BR_LEVEL_CHAIN_TIMEOUT_EN
        // A transfer completing on the deadline edge counts as reaching DONE.
        if ((r_state == S_CLAIM || r_state == S_MASTER) &&
            !(r_state == S_MASTER && ssyn_in_h)) begin
            if (r_tmo_cnt == c_TMO_LAST) begin
                w_state_n = S_IDLE;
                w_sack_n  = 1'b0;
                w_bbsy_n  = 1'b0;
                w_intr_n  = 1'b0;
                w_d_n     = 16'h0000;
                w_gnt_n   = '0;
                w_igvec_n = 8'h00;
                w_br_kill = 1'b1;
                w_stat_n  = 1'b1;
            end else begin
                w_tmo_cnt_n = r_tmo_cnt + 1'b1;
            end
        end
`endif

        w_br_n = w_any && !w_br_kill &&
                 (w_state_n == S_IDLE || w_state_n == S_CLAIM);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_winner   <= '0;
            r_vec      <= 8'h00;
            r_passed   <= 1'b0;
            bg_out_h   <= 1'b0;
            br_out_h   <= 1'b0;
            sack_out_h <= 1'b0;
            bbsy_out_h <= 1'b0;
            intr_out_h <= 1'b0;
            d_out_h    <= 16'h0000;
            dev_intgnt <= '0;
            dev_igvec  <= 8'h00;
        end else if (init_in_h) begin
            r_state    <= S_IDLE;
            r_winner   <= '0;
            r_vec      <= 8'h00;
            r_passed   <= 1'b0;
            bg_out_h   <= 1'b0;
            br_out_h   <= 1'b0;
            sack_out_h <= 1'b0;
            bbsy_out_h <= 1'b0;
            intr_out_h <= 1'b0;
            d_out_h    <= 16'h0000;
            dev_intgnt <= '0;
            dev_igvec  <= 8'h00;
        end else begin
            r_state    <= w_state_n;
            r_winner   <= w_winner_n;
            r_vec      <= w_vec_n;
            r_passed   <= w_passed_n;
            bg_out_h   <= w_bg_n;
            br_out_h   <= w_br_n;
            sack_out_h <= w_sack_n;
            bbsy_out_h <= w_bbsy_n;
            intr_out_h <= w_intr_n;
            d_out_h    <= w_d_n;
            dev_intgnt <= w_gnt_n;
            dev_igvec  <= w_igvec_n;
        end
    end

`ifdef BR_LEVEL_CHAIN_TIMEOUT_EN
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tmo_cnt    <= '0;
            stat_timeout <= 1'b0;
        end else if (init_in_h) begin
            r_tmo_cnt    <= '0;
            stat_timeout <= 1'b0;
        end else begin
            r_tmo_cnt    <= w_tmo_cnt_n;
            stat_timeout <= w_stat_n;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_br_level_chain.sv
//==============================================================================
// Module      : tb_br_level_chain
// Description : Self-checking bench for br_level_chain; the bench plays the
//               CPU side of the bus and predicts grants from priority rules.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_br_level_chain;

    localparam int NDEV = 4;
`ifdef BR_LEVEL_CHAIN_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 1000;
`endif

    logic              CLOCK = 1'b0;
    logic              RESET_N;
    logic [NDEV-1:0]   dev_intreq;
    logic [8*NDEV-1:0] dev_irvec;
    logic [NDEV-1:0]   dev_intgnt;
    logic [7:0]        dev_igvec;
    logic              init_in_h, bg_in_h, bg_out_h, bbsy_in_h, ssyn_in_h;
    logic              br_out_h, sack_out_h, bbsy_out_h, intr_out_h;
    logic [15:0]       d_out_h;
`ifdef BR_LEVEL_CHAIN_TIMEOUT_EN
    logic              stat_timeout;
`endif

    int checks = 0;
    int errors = 0;

    br_level_chain #(.NDEV(NDEV), .TIMEOUT_CYCLES(TMO)) u_dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .dev_intreq (dev_intreq),
        .dev_irvec  (dev_irvec),
        .dev_intgnt (dev_intgnt),
        .dev_igvec  (dev_igvec),
        .init_in_h  (init_in_h),
        .bg_in_h    (bg_in_h),
        .bg_out_h   (bg_out_h),
        .bbsy_in_h  (bbsy_in_h),
        .ssyn_in_h  (ssyn_in_h),
        .br_out_h   (br_out_h),
        .sack_out_h (sack_out_h),
        .bbsy_out_h (bbsy_out_h),
        .intr_out_h (intr_out_h),
        .d_out_h    (d_out_h)
`ifdef BR_LEVEL_CHAIN_TIMEOUT_EN
        ,
        .stat_timeout (stat_timeout)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    function automatic logic [37:0] all_outs();
        return {bg_out_h, br_out_h, sack_out_h, bbsy_out_h, intr_out_h, d_out_h, dev_intgnt, dev_igvec};
    endfunction

    // One full interrupt on the current dev_intreq: the expected winner and
    // vector come from the lowest set request bit at the moment BG is raised.
    task automatic service(input int hold, input int cpu_wait, input string tag);
        int          idx;
        logic [7:0]  exp_vec;
        logic [3:0]  exp_gnt;
        idx = -1;
        for (int i = NDEV - 1; i >= 0; i--) if (dev_intreq[i]) idx = i;
        if (idx < 0) begin
            checks++; errors++;
            $display("FAIL %s_setup: no request present", tag);
            return;
        end
        exp_vec = dev_irvec[8*idx +: 8];
        exp_gnt = 4'b0001 << idx;

        tick;
        checks++; if (br_out_h !== 1'b1) begin errors++; $display("FAIL %s_br: got %b want 1", tag, br_out_h); end

        bg_in_h   = 1'b1;
        bbsy_in_h = (hold > 0);
        tick;
        checks++; if ({sack_out_h, bg_out_h} !== 2'b10) begin errors++; $display("FAIL %s_sack: sack/bgout got %b want 10", tag, {sack_out_h, bg_out_h}); end

        dev_irvec = $urandom;   // must not affect the latched vector
        bg_in_h   = 1'b0;
        for (int k = 0; k < hold; k++) begin
            tick;
            checks++; if ({sack_out_h, intr_out_h} !== 2'b10) begin errors++; $display("FAIL %s_hold: sack/intr got %b want 10", tag, {sack_out_h, intr_out_h}); end
        end
        bbsy_in_h = 1'b0;
        tick;
        checks++; if ({intr_out_h, bbsy_out_h, sack_out_h, br_out_h} !== 4'b1100) begin errors++; $display("FAIL %s_master: intr/bbsy/sack/br got %b want 1100", tag, {intr_out_h, bbsy_out_h, sack_out_h, br_out_h}); end
        checks++; if (d_out_h !== {8'h00, exp_vec}) begin errors++; $display("FAIL %s_data: got %o want %o", tag, d_out_h, {8'h00, exp_vec}); end
        for (int k = 0; k < cpu_wait; k++) begin
            tick;
            checks++; if (intr_out_h !== 1'b1 || dev_intgnt !== 4'b0000) begin errors++; $display("FAIL %s_wait: intr %b gnt %b want 1 0000", tag, intr_out_h, dev_intgnt); end
        end

        ssyn_in_h = 1'b1;
        tick;
        checks++; if (dev_intgnt !== exp_gnt) begin errors++; $display("FAIL %s_gnt: got %b want %b", tag, dev_intgnt, exp_gnt); end
        checks++; if (dev_igvec !== exp_vec) begin errors++; $display("FAIL %s_igvec: got %o want %o", tag, dev_igvec, exp_vec); end
        checks++; if ({intr_out_h, bbsy_out_h, d_out_h} !== 18'h0) begin errors++; $display("FAIL %s_release: intr/bbsy/d got %b %b %h want 0", tag, intr_out_h, bbsy_out_h, d_out_h); end

        dev_intreq[idx] = 1'b0;
        tick;
        checks++; if ({dev_intgnt, dev_igvec} !== 12'h0) begin errors++; $display("FAIL %s_pulse: gnt %b igvec %h want 0", tag, dev_intgnt, dev_igvec); end

        ssyn_in_h = 1'b0;
        tick;
        checks++; if (br_out_h !== (|dev_intreq)) begin errors++; $display("FAIL %s_br_after: got %b want %b", tag, br_out_h, |dev_intreq); end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        #1;
        checks++; if (all_outs() !== 38'h0) begin errors++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
        tick; tick;
        RESET_N = 1'b1;
        tick;
        checks++; if (all_outs() !== 38'h0) begin errors++; $display("FAIL reset_idle: got %h want 0", all_outs()); end
    endtask

    task automatic test_single();
        dev_irvec  = {24'h0, 8'o100};
        dev_intreq = 4'b0001;
        service(0, 0, "single");
        dev_intreq = '0;
        tick;
    endtask

    task automatic test_priority();
        dev_intreq = 4'b0110;
        dev_irvec  = {8'h00, 8'o064, 8'o060, 8'h00};
        service(1, 1, "prio1");
        dev_irvec  = {8'h00, 8'o064, 8'o060, 8'h00};
        service(0, 2, "prio2");
        tick;
        checks++; if (br_out_h !== 1'b0) begin errors++; $display("FAIL prio_br_end: got %b want 0", br_out_h); end
    endtask

    task automatic test_passthrough();
        dev_intreq = '0;
        bg_in_h    = 1'b1;
        tick;
        checks++; if ({bg_out_h, sack_out_h} !== 2'b10) begin errors++; $display("FAIL pt_first: bgout/sack got %b want 10", {bg_out_h, sack_out_h}); end
        dev_intreq = 4'b0001;
        dev_irvec  = {24'h0, 8'o070};
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if ({bg_out_h, sack_out_h} !== 2'b10) begin errors++; $display("FAIL pt_hold: bgout/sack got %b want 10", {bg_out_h, sack_out_h}); end
        end
        bg_in_h = 1'b0;
        tick;
        checks++; if ({bg_out_h, sack_out_h} !== 2'b00) begin errors++; $display("FAIL pt_drop: bgout/sack got %b want 00", {bg_out_h, sack_out_h}); end
        service(0, 0, "pt_claim");
        dev_intreq = '0;
        tick;
    endtask

    task automatic test_passive_release();
        dev_intreq = 4'b0001;
        dev_irvec  = {24'h0, 8'o030};
        tick;
        bg_in_h = 1'b1;
        tick;
        checks++; if (sack_out_h !== 1'b1) begin errors++; $display("FAIL pr_sack: got %b want 1", sack_out_h); end
        bbsy_in_h  = 1'b1;
        bg_in_h    = 1'b0;
        dev_intreq = '0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if ({sack_out_h, intr_out_h} !== 2'b10) begin errors++; $display("FAIL pr_hold: sack/intr got %b want 10", {sack_out_h, intr_out_h}); end
        end
        bbsy_in_h = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (all_outs() !== 38'h0) begin errors++; $display("FAIL pr_release: outs got %h want 0", all_outs()); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            dev_intreq = 4'($urandom_range(1, 15));
            dev_irvec  = $urandom;
            service(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand");
        end
        dev_intreq = '0;
        tick;
    endtask

    task automatic test_reset_mid();
        dev_intreq = 4'b0001;
        dev_irvec  = {24'h0, 8'o100};
        tick;
        bg_in_h = 1'b1;
        tick;
        bg_in_h = 1'b0;
        tick;
        checks++; if (intr_out_h !== 1'b1) begin errors++; $display("FAIL rm_master: intr got %b want 1", intr_out_h); end
        RESET_N = 1'b0;
        #1;
        checks++; if (all_outs() !== 38'h0) begin errors++; $display("FAIL rm_async: outs got %h want 0", all_outs()); end
        tick;
        RESET_N = 1'b1;
        tick;
        checks++; if ({br_out_h, intr_out_h} !== 2'b10) begin errors++; $display("FAIL rm_after: br/intr got %b want 10", {br_out_h, intr_out_h}); end

        bg_in_h = 1'b1;
        tick;
        checks++; if (sack_out_h !== 1'b1) begin errors++; $display("FAIL init_claim: sack got %b want 1", sack_out_h); end
        init_in_h = 1'b1;
        bg_in_h   = 1'b0;
        tick;
        checks++; if (all_outs() !== 38'h0) begin errors++; $display("FAIL init_clear: outs got %h want 0", all_outs()); end
        init_in_h = 1'b0;
        tick;
        checks++; if ({br_out_h, sack_out_h} !== 2'b10) begin errors++; $display("FAIL init_idle: br/sack got %b want 10", {br_out_h, sack_out_h}); end
        dev_intreq = '0;
        tick;
    endtask

`ifdef BR_LEVEL_CHAIN_TIMEOUT_EN
    task automatic test_timeout();
        dev_intreq = 4'b0001;
        dev_irvec  = {24'h0, 8'o100};
        tick;
        bg_in_h = 1'b1;
        tick;   // SACK asserted on this edge
        bg_in_h   = 1'b0;
        bbsy_in_h = 1'b1;
        for (int k = 1; k < TMO; k++) begin
            tick;
            checks++; if ({sack_out_h, stat_timeout} !== 2'b10) begin errors++; $display("FAIL tmo_wait%0d: sack/stat got %b want 10", k, {sack_out_h, stat_timeout}); end
        end
        tick;
        checks++; if (all_outs() !== 38'h0) begin errors++; $display("FAIL tmo_drop: outs got %h want 0", all_outs()); end
        checks++; if (stat_timeout !== 1'b1) begin errors++; $display("FAIL tmo_stat: got %b want 1", stat_timeout); end
        bbsy_in_h  = 1'b0;
        dev_intreq = '0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if ({dev_intgnt, stat_timeout} !== 5'b00001) begin errors++; $display("FAIL tmo_sticky: gnt/stat got %b want 00001", {dev_intgnt, stat_timeout}); end
        end
        init_in_h = 1'b1;
        tick;
        init_in_h = 1'b0;
        checks++; if (stat_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", stat_timeout); end
        tick;
    endtask
`endif

    initial begin
        RESET_N    = 1'b0;
        dev_intreq = '0;
        dev_irvec  = '0;
        init_in_h  = 1'b0;
        bg_in_h    = 1'b0;
        bbsy_in_h  = 1'b0;
        ssyn_in_h  = 1'b0;
        #3;
        test_reset();
        test_single();
        test_priority();
        test_passthrough();
        test_passive_release();
        test_random();
        test_reset_mid();
`ifdef BR_LEVEL_CHAIN_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
